// File: rtl/addrgen_pkg.sv
// Shared constants and helpers for the multi-channel blitter address generator.
package addrgen_pkg;

    localparam int PHRASE_BITS  = 64;
    localparam int PHRASE_BYTES = 8;

    // Pixel size codes: bits per pixel = 1 << code.
    localparam logic [2:0] PS_1  = 3'd0;
    localparam logic [2:0] PS_2  = 3'd1;
    localparam logic [2:0] PS_4  = 3'd2;
    localparam logic [2:0] PS_8  = 3'd3;
    localparam logic [2:0] PS_16 = 3'd4;
    localparam logic [2:0] PS_32 = 3'd5;

    // Window width W = ((4+m) << e) >> 2; the result fits in 18 bits for any code.
    function automatic logic [31:0] width_decode(input logic [5:0] w);
        logic [31:0] t;
        t = {29'd0, 3'd4 + {1'b0, w[1:0]}} << w[5:2];
        return t >> 2;
    endfunction

endpackage

// File: rtl/addrgen_chsel.sv
// Combinational per-channel field mux from the packed configuration buses.
// An unmatched selector yields all-zero fields and raises oor.
module addrgen_chsel import addrgen_pkg::*; #(
    parameter int NCH = 2,
    parameter int AW  = 24,
    parameter int XW  = 16,
    parameter int CW  = 1
) (
    input  logic [CW-1:0]         sel,
    input  logic [NCH*XW-1:0]     ch_x,
    input  logic [NCH*XW-1:0]     ch_y,
    input  logic [NCH*(AW-3)-1:0] ch_base,
    input  logic [NCH*2-1:0]      ch_pitch,
    input  logic [NCH*3-1:0]      ch_pixsize,
    input  logic [NCH*6-1:0]      ch_width,
    input  logic [NCH*2-1:0]      ch_zoffset,
    output logic [XW-1:0]         x,
    output logic [XW-1:0]         y,
    output logic [AW-4:0]         base,
    output logic [1:0]            pitch,
    output logic [2:0]            pixsize,
    output logic [5:0]            width,
    output logic [1:0]            zoffset,
    output logic                  oor
);

    // Select the addressed channel's slice of every bus; flag out-of-range selectors.
    always_comb begin
        x       = '0;
        y       = '0;
        base    = '0;
        pitch   = '0;
        pixsize = '0;
        width   = '0;
        zoffset = '0;
        oor     = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (sel == CW'(i)) begin
                x       = ch_x[i*XW +: XW];
                y       = ch_y[i*XW +: XW];
                base    = ch_base[i*(AW-3) +: (AW-3)];
                pitch   = ch_pitch[i*2 +: 2];
                pixsize = ch_pixsize[i*3 +: 3];
                width   = ch_width[i*6 +: 6];
                zoffset = ch_zoffset[i*2 +: 2];
                oor     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/addrgen_multi.sv
// Pipelined multi-channel blitter address generator with valid/ready handshake.
// A capture register latches the request on acceptance, then S1 (partial
// products), S2 (index, shifts, clip) and S3 (final phrase, output regs).
// The whole pipe stalls together whenever the output is held.
module addrgen_multi import addrgen_pkg::*; #(
    parameter int NCH = 2,
    parameter int AW  = 24,
    parameter int XW  = 16,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  sys_clk,
    input  logic                  resetl,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CW-1:0]         req_ch,
    input  logic                  req_z,
    input  logic [NCH*XW-1:0]     ch_x,
    input  logic [NCH*XW-1:0]     ch_y,
    input  logic [NCH*(AW-3)-1:0] ch_base,
    input  logic [NCH*2-1:0]      ch_pitch,
    input  logic [NCH*3-1:0]      ch_pixsize,
    input  logic [NCH*6-1:0]      ch_width,
    input  logic [NCH*2-1:0]      ch_zoffset,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AW-1:0]         out_addr,
    output logic [2:0]            out_pixa,
    output logic [CW-1:0]         out_ch,
    output logic                  out_clip,
    output logic                  out_cfgerr
);

    localparam int FW = AW - 3;                 // phrase address width
    localparam int WW = XW + 2;                 // window width
    localparam int IW = 2*XW + 2;               // pixel index
    localparam int BW = IW + 5;                 // bit address
    localparam int PB = $clog2(PHRASE_BITS);    // bit-in-phrase width

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [XW-1:0] x;
        logic [XW-1:0] y;
        logic [FW-1:0] base;
        logic [1:0]    pitch;
        logic [2:0]    ps;
        logic [5:0]    width;
        logic [1:0]    zoff;
        logic          z;
        logic          oor;
    } s0_t;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [XW-1:0] x;
        logic [WW-1:0] wdec;
        logic [IW-1:0] pp0;
        logic [IW-1:0] pp1;
        logic [IW-1:0] pp2;
        logic [FW-1:0] base;
        logic [1:0]    pitch;
        logic [2:0]    ps;
        logic [1:0]    zadd;
        logic          cfgerr;
        logic          oor;
    } s1_t;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [FW-1:0] ph;
        logic [2:0]    pixa;
        logic          clip;
        logic [FW-1:0] base;
        logic [1:0]    pitch;
        logic [1:0]    zadd;
        logic          cfgerr;
        logic          oor;
    } s2_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [2:0]    pixa;
        logic [CW-1:0] ch;
        logic          clip;
        logic          cfgerr;
    } out_t;

    logic [3:0] vld_pipe_q, vld_pipe_d;
    s0_t        s0_q, s0_d;
    s1_t        s1_q, s1_d;
    s2_t        s2_q, s2_d;
    out_t       out_q, out_d;
    logic       en;

    logic [XW-1:0] sel_x, sel_y;
    logic [FW-1:0] sel_base;
    logic [1:0]    sel_pitch, sel_zoff;
    logic [2:0]    sel_ps;
    logic [5:0]    sel_width;
    logic          sel_oor;

    logic [3:0]    e;
    logic [1:0]    m;
    logic [WW-1:0] wdec;
    logic [IW-1:0] yw, pp0, pp1, pp2, idx;
    logic [BW-1:0] bitaddr;
    logic [FW-1:0] fp;

    addrgen_chsel #(.NCH(NCH), .AW(AW), .XW(XW), .CW(CW)) u_chsel (
        .sel        (req_ch),
        .ch_x       (ch_x),
        .ch_y       (ch_y),
        .ch_base    (ch_base),
        .ch_pitch   (ch_pitch),
        .ch_pixsize (ch_pixsize),
        .ch_width   (ch_width),
        .ch_zoffset (ch_zoffset),
        .x          (sel_x),
        .y          (sel_y),
        .base       (sel_base),
        .pitch      (sel_pitch),
        .pixsize    (sel_ps),
        .width      (sel_width),
        .zoffset    (sel_zoff),
        .oor        (sel_oor)
    );

    // Single stall enable: everything moves only when the output slot frees up.
    assign en        = !vld_pipe_q[3] || out_ready;
    assign req_ready = en;

    // Valid shift register; bubbles travel with the data.
    always_comb begin
        vld_pipe_d = en ? {vld_pipe_q[2:0], req_valid} : vld_pipe_q;
    end

    // Capture the selected channel's fields so later bus changes cannot leak in.
    always_comb begin
        s0_d = s0_q;
        if (en) begin
            s0_d.ch    = req_ch;
            s0_d.x     = sel_x;
            s0_d.y     = sel_y;
            s0_d.base  = sel_base;
            s0_d.pitch = sel_pitch;
            s0_d.ps    = sel_ps;
            s0_d.width = sel_width;
            s0_d.zoff  = sel_zoff;
            s0_d.z     = req_z;
            s0_d.oor   = sel_oor;
        end
    end

    // S1: decompose y*W into shifted copies of y. For e<2 the shift form
    // would floor each term separately, so use W's (at most two) bits directly.
    always_comb begin
        s1_d = s1_q;
        e    = s0_q.width[5:2];
        m    = s0_q.width[1:0];
        wdec = WW'(width_decode(s0_q.width));
        yw   = IW'(s0_q.y);
        if (e >= 4'd2) begin
            pp0 = yw << e;
            pp1 = m[1] ? (yw << (e - 4'd1)) : '0;
            pp2 = m[0] ? (yw << (e - 4'd2)) : '0;
        end else begin
            pp0 = wdec[0] ? yw : '0;
            pp1 = wdec[1] ? (yw << 1) : '0;
            pp2 = '0;
        end
        if (en) begin
            s1_d.ch     = s0_q.ch;
            s1_d.x      = s0_q.x;
            s1_d.wdec   = wdec;
            s1_d.pp0    = pp0;
            s1_d.pp1    = pp1;
            s1_d.pp2    = pp2;
            s1_d.base   = s0_q.base;
            s1_d.pitch  = s0_q.pitch;
            s1_d.ps     = (s0_q.ps > PS_32) ? PS_32 : s0_q.ps;
            s1_d.zadd   = s0_q.z ? s0_q.zoff : 2'd0;
            s1_d.cfgerr = s0_q.oor || (s0_q.ps > PS_32);
            s1_d.oor    = s0_q.oor;
        end
    end

    // S2: pixel index, bit address, phrase / byte split and the clip test.
    always_comb begin
        s2_d    = s2_q;
        idx     = s1_q.pp0 + s1_q.pp1 + s1_q.pp2 + IW'(s1_q.x);
        bitaddr = BW'(idx) << s1_q.ps;
        if (en) begin
            s2_d.ch     = s1_q.ch;
            s2_d.ph     = FW'(bitaddr >> PB);
            s2_d.pixa   = bitaddr[PB-1:3];
            s2_d.clip   = WW'(s1_q.x) >= s1_q.wdec;
            s2_d.base   = s1_q.base;
            s2_d.pitch  = s1_q.pitch;
            s2_d.zadd   = s1_q.zadd;
            s2_d.cfgerr = s1_q.cfgerr;
            s2_d.oor    = s1_q.oor;
        end
    end

    // S3: final phrase (wraps at FW bits) and output registers.
    always_comb begin
        out_d = out_q;
        fp    = s2_q.base + (s2_q.ph << s2_q.pitch) + FW'(s2_q.zadd);
        if (en) begin
            out_d.ch     = s2_q.ch;
            out_d.cfgerr = s2_q.cfgerr;
            if (s2_q.oor) begin
                out_d.addr = '0;
                out_d.pixa = '0;
                out_d.clip = 1'b0;
            end else begin
                out_d.addr = {fp, s2_q.pixa};
                out_d.pixa = s2_q.pixa;
                out_d.clip = s2_q.clip;
            end
        end
    end

    // State registers; reset drops everything in flight.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            vld_pipe_q <= '0;
            s0_q       <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            out_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            out_q      <= out_d;
        end
    end

    assign out_valid  = vld_pipe_q[3];
    assign out_addr   = out_q.addr;
    assign out_pixa   = out_q.pixa;
    assign out_ch     = out_q.ch;
    assign out_clip   = out_q.clip;
    assign out_cfgerr = out_q.cfgerr;

endmodule

// File: tb/tb_addrgen_multi.sv
// Directed bench for addrgen_multi: vector table plus hand-written sequences.
module tb_addrgen_multi;

    localparam int NCH = 3;
    localparam int AW  = 24;
    localparam int XW  = 16;
    localparam int CW  = 2;
    localparam int FW  = AW - 3;

    logic                  sys_clk = 1'b0;
    logic                  resetl  = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic [CW-1:0]         req_ch = '0;
    logic                  req_z  = 1'b0;
    logic [NCH*XW-1:0]     ch_x = '0;
    logic [NCH*XW-1:0]     ch_y = '0;
    logic [NCH*FW-1:0]     ch_base = '0;
    logic [NCH*2-1:0]      ch_pitch = '0;
    logic [NCH*3-1:0]      ch_pixsize = '0;
    logic [NCH*6-1:0]      ch_width = '0;
    logic [NCH*2-1:0]      ch_zoffset = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [AW-1:0]         out_addr;
    logic [2:0]            out_pixa;
    logic [CW-1:0]         out_ch;
    logic                  out_clip;
    logic                  out_cfgerr;

    addrgen_multi #(.NCH(NCH), .AW(AW), .XW(XW), .CW(CW)) dut (
        .sys_clk    (sys_clk),
        .resetl     (resetl),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ch     (req_ch),
        .req_z      (req_z),
        .ch_x       (ch_x),
        .ch_y       (ch_y),
        .ch_base    (ch_base),
        .ch_pitch   (ch_pitch),
        .ch_pixsize (ch_pixsize),
        .ch_width   (ch_width),
        .ch_zoffset (ch_zoffset),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_pixa   (out_pixa),
        .out_ch     (out_ch),
        .out_clip   (out_clip),
        .out_cfgerr (out_cfgerr)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [1:0]    ch;
        logic [15:0]   x;
        logic [15:0]   y;
        logic [FW-1:0] base;
        logic [1:0]    pitch;
        logic [2:0]    ps;
        logic [3:0]    e;
        logic [1:0]    m;
        logic [1:0]    zoff;
        logic          z;
        logic [AW-1:0] ea;
        logic [2:0]    epix;
        logic          eclip;
        logic          eerr;
    } vec_t;

    vec_t          vecs[12];
    logic [AW-1:0] bp_exp[6];
    int            total  = 0;
    int            passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic set_ch(input int c, input logic [15:0] x, input logic [15:0] y,
                          input logic [FW-1:0] base, input logic [1:0] pitch,
                          input logic [2:0] ps, input logic [3:0] e, input logic [1:0] m,
                          input logic [1:0] zoff);
        ch_x[c*XW +: XW]       = x;
        ch_y[c*XW +: XW]       = y;
        ch_base[c*FW +: FW]    = base;
        ch_pitch[c*2 +: 2]     = pitch;
        ch_pixsize[c*3 +: 3]   = ps;
        ch_width[c*6 +: 6]     = {e, m};
        ch_zoffset[c*2 +: 2]   = zoff;
    endtask

    // One isolated request: check acceptance, exact 3-edge latency and all result fields.
    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge sys_clk);
        if (int'(v.ch) < NCH) set_ch(int'(v.ch), v.x, v.y, v.base, v.pitch, v.ps, v.e, v.m, v.zoff);
        req_ch    = v.ch;
        req_z     = v.z;
        req_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk($sformatf("v%0d_req_ready", idx), 32'(req_ready), 32'd1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        req_valid = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk($sformatf("v%0d_latency_early", idx), 32'(out_valid), 32'd0);
        @(negedge sys_clk);
        chk($sformatf("v%0d_valid", idx), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d_addr", idx), 32'(out_addr), 32'(v.ea));
        chk($sformatf("v%0d_pixa", idx), 32'(out_pixa), 32'(v.epix));
        chk($sformatf("v%0d_clip", idx), 32'(out_clip), 32'(v.eclip));
        chk($sformatf("v%0d_cfgerr", idx), 32'(out_cfgerr), 32'(v.eerr));
        chk($sformatf("v%0d_ch", idx), 32'(out_ch), 32'(v.ch));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            ch    x      y      base        pt    ps    e     m     zo    z     addr        pixa  clip  err
        vecs[0]  = '{2'd0, 16'd5,  16'd2, 21'h100,    2'd0, 3'd4, 4'd6, 2'd0, 2'd0, 1'b0, 24'h90A,   3'd2, 1'b0, 1'b0};
        vecs[1]  = '{2'd0, 16'd5,  16'd2, 21'h100,    2'd0, 3'd4, 4'd6, 2'd0, 2'd1, 1'b1, 24'h912,   3'd2, 1'b0, 1'b0};
        vecs[2]  = '{2'd0, 16'd5,  16'd2, 21'h100,    2'd1, 3'd4, 4'd6, 2'd0, 2'd1, 1'b0, 24'hA12,   3'd2, 1'b0, 1'b0};
        vecs[3]  = '{2'd0, 16'd80, 16'd0, 21'h100,    2'd0, 3'd4, 4'd6, 2'd1, 2'd0, 1'b0, 24'h8A0,   3'd0, 1'b1, 1'b0};
        vecs[4]  = '{2'd0, 16'd79, 16'd0, 21'h100,    2'd0, 3'd4, 4'd6, 2'd1, 2'd0, 1'b0, 24'h89E,   3'd6, 1'b0, 1'b0};
        vecs[5]  = '{2'd0, 16'd5,  16'd2, 21'h100,    2'd0, 3'd7, 4'd6, 2'd0, 2'd0, 1'b0, 24'hA14,   3'd4, 1'b0, 1'b1};
        vecs[6]  = '{2'd1, 16'd7,  16'd3, 21'h20,     2'd0, 3'd0, 4'd3, 2'd2, 2'd0, 1'b0, 24'h105,   3'd5, 1'b0, 1'b0};
        vecs[7]  = '{2'd1, 16'd2,  16'd4, 21'h0,      2'd2, 3'd3, 4'd1, 2'd3, 2'd3, 1'b1, 24'h3E,    3'd6, 1'b0, 1'b0};
        vecs[8]  = '{2'd2, 16'd2,  16'd0, 21'h1FFFFF, 2'd0, 3'd5, 4'd6, 2'd0, 2'd0, 1'b0, 24'h0,     3'd0, 1'b0, 1'b0};
        vecs[9]  = '{2'd2, 16'd1,  16'd5, 21'h10,     2'd0, 3'd3, 4'd0, 2'd0, 2'd0, 1'b0, 24'h86,    3'd6, 1'b1, 1'b0};
        vecs[10] = '{2'd3, 16'd9,  16'd9, 21'h55,     2'd1, 3'd2, 4'd6, 2'd0, 2'd1, 1'b1, 24'h0,     3'd0, 1'b0, 1'b1};
        vecs[11] = '{2'd0, 16'd0,  16'd3, 21'h0,      2'd0, 3'd5, 4'd4, 2'd3, 2'd0, 1'b0, 24'h150,   3'd0, 1'b0, 1'b0};
        bp_exp   = '{24'h800, 24'h101, 24'h804, 24'h103, 24'h808, 24'h105};

        // Reset state
        #12;
        chk("rst_valid",  32'(out_valid),  32'd0);
        chk("rst_ready",  32'(req_ready),  32'd1);
        chk("rst_addr",   32'(out_addr),   32'd0);
        chk("rst_pixa",   32'(out_pixa),   32'd0);
        chk("rst_ch",     32'(out_ch),     32'd0);
        chk("rst_clip",   32'(out_clip),   32'd0);
        chk("rst_cfgerr", 32'(out_cfgerr), 32'd0);
        @(negedge sys_clk);
        resetl = 1'b1;

        for (int i = 0; i < 12; i++) apply_vec(vecs[i], i);

        // Config capture: base changes right after acceptance must not affect the result.
        begin
            logic seen;
            seen = 1'b0;
            @(negedge sys_clk);
            set_ch(0, 16'd5, 16'd2, 21'h100, 2'd0, 3'd4, 4'd6, 2'd0, 2'd0);
            req_ch = 2'd0; req_z = 1'b0; req_valid = 1'b1; out_ready = 1'b1;
            @(posedge sys_clk);
            @(negedge sys_clk);
            req_valid = 1'b0;
            ch_base[0 +: FW] = 21'h200;
            ch_x[0 +: XW]    = 16'd9;
            for (int k = 0; k < 8 && !seen; k++) begin
                @(negedge sys_clk);
                if (out_valid) seen = 1'b1;
            end
            chk("cap_seen", 32'(seen), 32'd1);
            chk("cap_addr", 32'(out_addr), 32'h90A);
        end

        // Backpressure: 6 back-to-back requests, ch0/ch1 alternating, irregular out_ready.
        begin
            logic [31:0]   rdy_pat;
            logic          stalled, acc;
            logic [AW-1:0] held_addr;
            logic [CW-1:0] held_ch;
            int            sent, got;
            rdy_pat = 32'b1011_0010_1101_0011_1001_0110_0101_1100;
            stalled = 1'b0; sent = 0; got = 0;
            held_addr = '0; held_ch = '0;
            @(negedge sys_clk);
            set_ch(0, 16'd0, 16'd0, 21'h100, 2'd0, 3'd4, 4'd6, 2'd0, 2'd0);
            set_ch(1, 16'd0, 16'd0, 21'h20,  2'd0, 3'd3, 4'd6, 2'd0, 2'd0);
            for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
                @(negedge sys_clk);
                out_ready = rdy_pat[cyc % 32];
                if (sent < 6) begin
                    req_valid = 1'b1;
                    req_ch    = 2'(sent % 2);
                    req_z     = 1'b0;
                    ch_x[(sent % 2)*XW +: XW] = 16'(sent);
                end else begin
                    req_valid = 1'b0;
                end
                #1;
                if (stalled) begin
                    chk($sformatf("bp_hold_valid_c%0d", cyc), 32'(out_valid), 32'd1);
                    chk($sformatf("bp_hold_addr_c%0d", cyc), 32'(out_addr), 32'(held_addr));
                    chk($sformatf("bp_hold_ch_c%0d", cyc), 32'(out_ch), 32'(held_ch));
                end
                if (out_valid && out_ready) begin
                    chk($sformatf("bp_addr_%0d", got), 32'(out_addr), 32'(bp_exp[got]));
                    chk($sformatf("bp_ch_%0d", got), 32'(out_ch), 32'(got % 2));
                    got++;
                end
                stalled   = out_valid && !out_ready;
                held_addr = out_addr;
                held_ch   = out_ch;
                acc       = req_valid && req_ready;
                @(posedge sys_clk);
                if (acc) sent++;
            end
            chk("bp_count", 32'(got), 32'd6);
            @(negedge sys_clk);
            req_valid = 1'b0;
            out_ready = 1'b1;
            repeat (4) @(negedge sys_clk);
            chk("bp_no_extra", 32'(out_valid), 32'd0);
        end

        // Reset with two requests in flight: they must never appear.
        begin
            logic seen;
            seen = 1'b0;
            @(negedge sys_clk);
            set_ch(0, 16'd5, 16'd2, 21'h100, 2'd0, 3'd4, 4'd6, 2'd0, 2'd0);
            req_ch = 2'd0; req_z = 1'b0; req_valid = 1'b1; out_ready = 1'b1;
            @(posedge sys_clk);
            @(posedge sys_clk);
            @(negedge sys_clk);
            req_valid = 1'b0;
            #2 resetl = 1'b0;
            #1;
            chk("rstmid_valid",  32'(out_valid),  32'd0);
            chk("rstmid_ready",  32'(req_ready),  32'd1);
            chk("rstmid_addr",   32'(out_addr),   32'd0);
            chk("rstmid_cfgerr", 32'(out_cfgerr), 32'd0);
            @(negedge sys_clk);
            resetl = 1'b1;
            repeat (6) begin
                @(negedge sys_clk);
                if (out_valid) seen = 1'b1;
            end
            chk("rstmid_no_ghost", 32'(seen), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
